// File: rtl/adder_421_pipe.sv
// Pipelined signed 4-operand adder/subtractor S = A +/- B +/- C +/- D, one STAGE_WIDTH chunk per stage.
// Optional ADDER421_OVF_EN adds an ovf output flagging results outside the signed IN_WIDTH range.
module adder_421_pipe #(
    parameter int IN_WIDTH    = 256,
    parameter int STAGE_WIDTH = 64,
    parameter bit SUB_B       = 1'b0,
    parameter bit SUB_C       = 1'b0,
    parameter bit SUB_D       = 1'b0,
    parameter bit REG_IN_CAS  = 1'b0,
    parameter bit REG_OUT_CAS = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] A,
    input  logic [IN_WIDTH-1:0] B,
    input  logic [IN_WIDTH-1:0] C,
    input  logic [IN_WIDTH-1:0] D,
    output logic [IN_WIDTH-1:0] S,
    output logic                out_valid
`ifdef ADDER421_OVF_EN
    ,
    output logic                ovf
`endif
);

    localparam int NSTG = (IN_WIDTH + STAGE_WIDTH - 1) / STAGE_WIDTH;
    // The "+1" of every two's-complement negation is folded into the chunk-0 carry.
    localparam logic [1:0] CIN0 = 2'(SUB_B) + 2'(SUB_C) + 2'(SUB_D);

    logic [IN_WIDTH-1:0] a_x, b_x, c_x, d_x;
    logic                vld_x;

    if (REG_IN_CAS) begin : g_in_reg
        always_ff @(posedge clk) begin
            if (!resetn) begin
                a_x   <= '0;
                b_x   <= '0;
                c_x   <= '0;
                d_x   <= '0;
                vld_x <= 1'b0;
            end else begin
                a_x   <= A;
                b_x   <= SUB_B ? ~B : B;
                c_x   <= SUB_C ? ~C : C;
                d_x   <= SUB_D ? ~D : D;
                vld_x <= in_valid;
            end
        end
    end else begin : g_in_comb
        assign a_x   = A;
        assign b_x   = SUB_B ? ~B : B;
        assign c_x   = SUB_C ? ~C : C;
        assign d_x   = SUB_D ? ~D : D;
        assign vld_x = in_valid;
    end

    // Stage k carries only the operand bits it and later stages still need, plus the result bits so far.
    for (genvar k = 0; k < NSTG; k++) begin : stg
        localparam int LO = k * STAGE_WIDTH;
        localparam int HI = ((k + 1) * STAGE_WIDTH < IN_WIDTH) ? (k + 1) * STAGE_WIDTH - 1 : IN_WIDTH - 1;
        localparam int CW = HI - LO + 1;

        logic [IN_WIDTH-1:LO] a_i, b_i, c_i, d_i;
        logic [1:0]           cin;
        logic                 vld_i;
        logic [CW+1:0]        sum;
        logic [HI:0]          res_d;
        logic [HI:0]          res_q;
        logic                 vld_q;

        assign sum = {2'b00, a_i[HI:LO]} + {2'b00, b_i[HI:LO]}
                   + {2'b00, c_i[HI:LO]} + {2'b00, d_i[HI:LO]}
                   + {{CW{1'b0}}, cin};

        if (k == 0) begin : g_src
            assign a_i   = a_x;
            assign b_i   = b_x;
            assign c_i   = c_x;
            assign d_i   = d_x;
            assign cin   = CIN0;
            assign vld_i = vld_x;
            assign res_d = sum[CW-1:0];
        end else begin : g_src
            assign a_i   = stg[k-1].g_fwd.op_a_q;
            assign b_i   = stg[k-1].g_fwd.op_b_q;
            assign c_i   = stg[k-1].g_fwd.op_c_q;
            assign d_i   = stg[k-1].g_fwd.op_d_q;
            assign cin   = stg[k-1].g_fwd.cy_q;
            assign vld_i = stg[k-1].vld_q;
            assign res_d = {sum[CW-1:0], stg[k-1].res_q};
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                res_q <= '0;
                vld_q <= 1'b0;
            end else begin
                res_q <= res_d;
                vld_q <= vld_i;
            end
        end

        if (k < NSTG - 1) begin : g_fwd
            logic [IN_WIDTH-1:HI+1] op_a_q, op_b_q, op_c_q, op_d_q;
            logic [1:0]             cy_q;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    op_a_q <= '0;
                    op_b_q <= '0;
                    op_c_q <= '0;
                    op_d_q <= '0;
                    cy_q   <= '0;
                end else begin
                    op_a_q <= a_i[IN_WIDTH-1:HI+1];
                    op_b_q <= b_i[IN_WIDTH-1:HI+1];
                    op_c_q <= c_i[IN_WIDTH-1:HI+1];
                    op_d_q <= d_i[IN_WIDTH-1:HI+1];
                    cy_q   <= sum[CW+1:CW];
                end
            end
        end else begin : g_last
            // Carry out of the top chunk is the modulo wrap and is dropped.
            logic unused_cout;
            assign unused_cout = ^sum[CW+1:CW];
`ifdef ADDER421_OVF_EN
            logic [CW+2:0] sum_x;
            logic          ovf_q;
            logic          unused_x;

            // Sign-extended top chunk: exact result fits iff the guard bits match the result sign.
            assign sum_x = {{3{a_i[HI]}}, a_i[HI:LO]} + {{3{b_i[HI]}}, b_i[HI:LO]}
                         + {{3{c_i[HI]}}, c_i[HI:LO]} + {{3{d_i[HI]}}, d_i[HI:LO]}
                         + {{(CW+1){1'b0}}, cin};
            assign unused_x = ^sum_x;

            always_ff @(posedge clk) begin
                if (!resetn) ovf_q <= 1'b0;
                else         ovf_q <= (sum_x[CW+2:CW] != {3{sum_x[CW-1]}});
            end
`endif
        end
    end

    logic [IN_WIDTH-1:0] s_core;
    logic                v_core;
    assign s_core = stg[NSTG-1].res_q;
    assign v_core = stg[NSTG-1].vld_q;
`ifdef ADDER421_OVF_EN
    logic ovf_core;
    assign ovf_core = stg[NSTG-1].g_last.ovf_q;
`endif

    if (REG_OUT_CAS) begin : g_out_reg
        always_ff @(posedge clk) begin
            if (!resetn) begin
                S         <= '0;
                out_valid <= 1'b0;
`ifdef ADDER421_OVF_EN
                ovf       <= 1'b0;
`endif
            end else begin
                S         <= s_core;
                out_valid <= v_core;
`ifdef ADDER421_OVF_EN
                ovf       <= ovf_core;
`endif
            end
        end
    end else begin : g_out_comb
        assign S         = s_core;
        assign out_valid = v_core;
`ifdef ADDER421_OVF_EN
        assign ovf       = ovf_core;
`endif
    end

endmodule

// File: tb/tb_adder_421_pipe.sv
// Bench for adder_421_pipe: eight 256/64 instances (all SUB combinations) and one 200-bit instance
// with input/output cascade registers, all fed the same stream and checked against a queue scoreboard.
module tb_adder_421_pipe;
    localparam int NI = 9;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic                    in_valid;
    logic [255:0]            A, B, C, D;
    logic [NI-1:0][255:0]    s_all;
    logic [NI-1:0]           v_all;
    logic [199:0]            s_200;
`ifdef ADDER421_OVF_EN
    logic [NI-1:0]           ovf_all;
`endif
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] s;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t sb_q [NI][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 8; g++) begin : g_dut
        adder_421_pipe #(
            .IN_WIDTH(256), .STAGE_WIDTH(64),
            .SUB_B((g & 1) != 0), .SUB_C((g & 2) != 0), .SUB_D((g & 4) != 0),
            .REG_IN_CAS(1'b0), .REG_OUT_CAS(1'b0)
        ) u_dut (
            .clk(clk), .resetn(resetn), .in_valid(in_valid),
            .A(A), .B(B), .C(C), .D(D),
            .S(s_all[g]), .out_valid(v_all[g])
`ifdef ADDER421_OVF_EN
            , .ovf(ovf_all[g])
`endif
        );
    end

    adder_421_pipe #(
        .IN_WIDTH(200), .STAGE_WIDTH(64),
        .SUB_B(1'b1), .SUB_C(1'b0), .SUB_D(1'b1),
        .REG_IN_CAS(1'b1), .REG_OUT_CAS(1'b1)
    ) u_dut_200 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid),
        .A(A[199:0]), .B(B[199:0]), .C(C[199:0]), .D(D[199:0]),
        .S(s_200), .out_valid(v_all[8])
`ifdef ADDER421_OVF_EN
        , .ovf(ovf_all[8])
`endif
    );
    assign s_all[8] = {56'd0, s_200};

    // Exact signed arithmetic on w-bit operands; S is the low w bits, ovf flags leaving the signed range.
    function automatic void model(input int combo, input int w,
                                  input logic [255:0] a, input logic [255:0] b,
                                  input logic [255:0] c, input logic [255:0] d,
                                  output logic [255:0] s, output logic ovf);
        logic signed [259:0] xa, xb, xc, xd, ex, lim;
        logic [255:0]        mask;
        int                  sh;
        sh = 260 - w;
        xa = $signed({4'b0, a} << sh) >>> sh;
        xb = $signed({4'b0, b} << sh) >>> sh;
        xc = $signed({4'b0, c} << sh) >>> sh;
        xd = $signed({4'b0, d} << sh) >>> sh;
        ex = xa;
        ex = ((combo & 1) != 0) ? ex - xb : ex + xb;
        ex = ((combo & 2) != 0) ? ex - xc : ex + xc;
        ex = ((combo & 4) != 0) ? ex - xd : ex + xd;
        mask = (w >= 256) ? {256{1'b1}} : ((256'd1 << w) - 256'd1);
        s    = ex[255:0] & mask;
        lim  = 260'sd1 <<< (w - 1);
        ovf  = (ex >= lim) || (ex < -lim);
    endfunction

    function automatic logic [255:0] rnd254();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        r[255:254] = {2{r[253]}};
        return r;
    endfunction

    task automatic drive(input logic v, input logic [255:0] a, input logic [255:0] b,
                         input logic [255:0] c, input logic [255:0] d);
        exp_t         e;
        logic [255:0] s_e;
        logic         o_e;
        in_valid = v;
        A = a; B = b; C = c; D = d;
        if (v) begin
            for (int g = 0; g < NI; g++) begin
                model((g < 8) ? g : 5, (g < 8) ? 256 : 200, a, b, c, d, s_e, o_e);
                e.s   = s_e;
                e.ovf = o_e;
                e.due = cyc + ((g < 8) ? 4 : 6);
                sb_q[g].push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rnd254(), rnd254(), rnd254(), rnd254());
    endtask

    task automatic check_reset_state(input string tag);
        for (int g = 0; g < NI; g++) begin
            checks++;
            assert (s_all[g] === 256'd0) else begin
                errors++;
                $error("FAIL %s_s[%0d] observed %h expected 0", tag, g, s_all[g]);
            end
            checks++;
            assert (v_all[g] === 1'b0) else begin
                errors++;
                $error("FAIL %s_valid[%0d] observed %b expected 0", tag, g, v_all[g]);
            end
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_mon
        exp_t e;
        always @(negedge clk) begin
            if (v_all[g] === 1'b1) begin
                checks++;
                assert (sb_q[g].size() > 0) else begin
                    errors++;
                    $error("FAIL spurious_valid[%0d] observed out_valid=1 expected 0 at cycle %0d", g, cyc);
                end
                if (sb_q[g].size() > 0) begin
                    e = sb_q[g].pop_front();
                    checks++;
                    assert (s_all[g] === e.s) else begin
                        errors++;
                        $error("FAIL sum[%0d] observed %h expected %h", g, s_all[g], e.s);
                    end
                    checks++;
                    assert (cyc == e.due) else begin
                        errors++;
                        $error("FAIL latency[%0d] observed cycle %0d expected cycle %0d", g, cyc, e.due);
                    end
`ifdef ADDER421_OVF_EN
                    checks++;
                    assert (ovf_all[g] === e.ovf) else begin
                        errors++;
                        $error("FAIL ovf[%0d] observed %b expected %b", g, ovf_all[g], e.ovf);
                    end
`endif
                end
            end
        end
    end

    initial begin
        resetn   = 1'b0;
        in_valid = 1'b0;
        A = '0; B = '0; C = '0; D = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        resetn = 1'b1;

        drive(1'b1, 256'd10, 256'd3, 256'd2, 256'd1);
        idle(8);
        drive(1'b1, {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 256'd0, 256'd0);
        idle(8);
        drive(1'b1, 256'd0, 256'd1, 256'd1, 256'd1);
        idle(8);
        drive(1'b1, {1'b0, {255{1'b1}}}, {256{1'b1}}, 256'd0, 256'd0);
        idle(8);

        for (int i = 0; i < 120; i++) drive(1'b1, rnd254(), rnd254(), rnd254(), rnd254());
        idle(8);

        for (int i = 0; i < 20; i++) drive(1'b1, rnd254(), rnd254(), rnd254(), rnd254());
        resetn   = 1'b0;
        in_valid = 1'b1;
        A = rnd254(); B = rnd254(); C = rnd254(); D = rnd254();
        @(negedge clk);
        for (int g = 0; g < NI; g++) sb_q[g].delete();
        check_reset_state("midreset");
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b1, rnd254(), rnd254(), rnd254(), rnd254());
        idle(12);

        for (int g = 0; g < NI; g++) begin
            checks++;
            assert (sb_q[g].size() == 0) else begin
                errors++;
                $error("FAIL drain[%0d] observed %0d outstanding results expected 0", g, sb_q[g].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
